mul_metronome: RTL

Sequencer that drives one `signed_multiplier` PE. It accepts signed operand pairs over a valid/ready stream and issues the PE's load strobe, bit index (`last_count`) and metronome strobe cycle by cycle. It captures each `2*BITWIDTH`-bit product into a small result FIFO and presents it downstream over valid/ready. It sits between the PE-array feeder and the PE, as the initiator side of the PE's serial-multiply protocol.

---
 rtl/mul_metronome_pkg.sv | 25 ++
 rtl/mul_result_fifo.sv | 52 +++++
 rtl/mul_metronome.sv | 112 +++++++++++
 3 files changed

// File: rtl/mul_metronome_pkg.sv
// Shared definitions for the signed_multiplier sequencer: FSM states and
// the bit-index width helper common to the PE and its metronome.
package mul_metronome_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        WAIT = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned last_count_width(input int unsigned bitwidth);
        return clog2(bitwidth) + 2;
    endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Small synchronous result FIFO; head entry is presented combinationally.
module mul_result_fifo
    import mul_metronome_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [clog2(DEPTH):0]    count
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/mul_metronome.sv
// Initiator side of the serial signed multiply: loads the PE, steps its bit
// index, strobes the metronome and queues each product for downstream.
module mul_metronome
    import mul_metronome_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [BITWIDTH-1:0]                    in_a,
    input  logic [BITWIDTH-1:0]                    in_b,
    output logic                                   pe_data_in_valid,
    output logic [BITWIDTH-1:0]                    pe_a,
    output logic [BITWIDTH-1:0]                    pe_b,
    output logic [last_count_width(BITWIDTH)-1:0]  pe_last_count,
    output logic                                   pe_metronome_valid,
    input  logic                                   pe_data_out_valid,
    input  logic [2*BITWIDTH-1:0]                  pe_dout,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [2*BITWIDTH-1:0]                  out_data,
    output logic                                   busy,
    output logic                                   err
);

    localparam int unsigned    LCW      = last_count_width(BITWIDTH);
    localparam int unsigned    CW       = clog2(DEPTH) + 1;
    localparam logic [LCW-1:0] LAST_IDX = LCW'(BITWIDTH - 1);

    state_t              state;
    state_t              next_state;
    logic [LCW-1:0]      count_next;
    logic                metro_next;
    logic                err_next;
    logic                accept;
    logic                push;
    logic                pop;
    logic [CW-1:0]       fifo_count;
    logic [2*BITWIDTH-1:0] fifo_head;

    // Gating with rst keeps in_ready low while reset is held.
    assign in_ready = rst && (state == IDLE) && (fifo_count < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = (state == WAIT) && pe_data_out_valid;
    assign out_valid = (fifo_count != '0);
    assign pop      = out_valid && out_ready;
    assign out_data = out_valid ? fifo_head : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            pe_a               <= '0;
            pe_b               <= '0;
            pe_data_in_valid   <= 1'b0;
            pe_last_count      <= '0;
            pe_metronome_valid <= 1'b0;
            busy               <= 1'b0;
            err                <= 1'b0;
        end else begin
            state              <= next_state;
            pe_data_in_valid   <= accept;
            pe_last_count      <= count_next;
            pe_metronome_valid <= metro_next;
            busy               <= (next_state != IDLE);
            err                <= err_next;
            if (accept) begin
                pe_a <= in_a;
                pe_b <= in_b;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN:     if (pe_last_count == LAST_IDX) next_state = WAIT;
            WAIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead from the next state.
    always_comb begin
        count_next = '0;
        if ((state == RUN) && (pe_last_count != LAST_IDX)) begin
            count_next = pe_last_count + LCW'(1);
        end
        metro_next = (next_state == RUN) && (count_next == LAST_IDX);
        err_next   = err
                   | (pe_data_out_valid && (state != WAIT))
                   | (!pe_data_out_valid && (state == WAIT));
    end

    mul_result_fifo #(
        .WIDTH (2*BITWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pe_dout),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

endmodule
